// File: rtl/ysyx_23060201_ifu.sv
// Multicycle instruction fetch unit: REQ/WAIT memory handshake, HOLD for the IDU, EXEC for dnpc.
// Optional perf counters (fetch_cnt, stall_cnt) are enabled by YSYX_23060201_IFU_PERF_EN.
module ysyx_23060201_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_raddr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc
`ifdef YSYX_23060201_IFU_PERF_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
`endif
);

  localparam logic [31:0] PcMask      = 32'hFFFF_FFFC;
  localparam logic [31:0] ResetPcAlgn = RESET_PC & PcMask;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StExec
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          inst_d  = mem_rsp_data;
          state_d = StHold;
        end
      end
      StHold: begin
        if (inst_ready) begin
          if (dnpc_valid) begin
            pc_d    = dnpc & PcMask;
            state_d = StReq;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (dnpc_valid) begin
          pc_d    = dnpc & PcMask;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= ResetPcAlgn;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Handshake outputs are decoded from state only, so no input reaches an output combinationally.
  assign mem_req_valid = (state_q == StReq);
  assign inst_valid    = (state_q == StHold);
  assign mem_raddr     = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;

`ifdef YSYX_23060201_IFU_PERF_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (inst_valid && inst_ready) fetch_cnt_d = fetch_cnt_q + 64'd1;
    if (((state_q == StReq) && !mem_req_ready) || ((state_q == StWait) && !mem_rsp_valid)) begin
      stall_cnt_d = stall_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Directed bench for ysyx_23060201_ifu; counter checks compile in with YSYX_23060201_IFU_PERF_EN.
module tb_ysyx_23060201_ifu;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_raddr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        dnpc_valid;
  logic [31:0] dnpc;
`ifdef YSYX_23060201_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  int checks = 0;
  int passed = 0;

  ysyx_23060201_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_raddr    (mem_raddr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .pc           (pc),
    .dnpc_valid   (dnpc_valid),
    .dnpc         (dnpc)
`ifdef YSYX_23060201_IFU_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    inst_ready = 1'b0; dnpc_valid = 1'b0; dnpc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b want 0", mem_req_valid); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %0b want 0", inst_valid); else passed++;
    checks++; if (pc !== 32'h8000_0000) $display("FAIL rst_pc got %h want 80000000", pc); else passed++;
    checks++; if (inst !== 32'h0) $display("FAIL rst_inst got %h want 0", inst); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL release_cycle_req got %0b want 0", mem_req_valid); else passed++;
    tick();
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL first_req_valid got %0b want 1", mem_req_valid); else passed++;
    checks++; if (mem_raddr !== 32'h8000_0000) $display("FAIL first_raddr got %h want 80000000", mem_raddr); else passed++;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
    checks++; if (inst_valid !== 1'b0) $display("FAIL wait_inst_valid got %0b want 0", inst_valid); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL wait_req_valid got %0b want 0", mem_req_valid); else passed++;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'hdead_beef;
    checks++; if (inst_valid !== 1'b1) $display("FAIL first_inst_valid got %0b want 1", inst_valid); else passed++;
    checks++; if (inst !== 32'h0000_0413) $display("FAIL first_inst got %h want 00000413", inst); else passed++;
  endtask

  task automatic test_hold_backpressure();
    for (int i = 0; i < 4; i++) begin
      dnpc_valid = (i == 2); dnpc = 32'h8000_0040;
      tick();
      checks++; if (inst_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %0b want 1", i, inst_valid); else passed++;
      checks++; if (inst !== 32'h0000_0413) $display("FAIL hold_inst[%0d] got %h want 00000413", i, inst); else passed++;
      checks++; if (pc !== 32'h8000_0000) $display("FAIL hold_pc[%0d] got %h want 80000000", i, pc); else passed++;
    end
    inst_ready = 1'b1; dnpc_valid = 1'b1; dnpc = 32'h8000_0010;
    tick();
    inst_ready = 1'b0; dnpc_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL hs_inst_valid got %0b want 0", inst_valid); else passed++;
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL hs_req_valid got %0b want 1", mem_req_valid); else passed++;
    checks++; if (mem_raddr !== 32'h8000_0010) $display("FAIL hs_raddr got %h want 80000010", mem_raddr); else passed++;
  endtask

  task automatic test_req_stall();
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req_valid !== 1'b1) $display("FAIL stall_req_valid[%0d] got %0b want 1", i, mem_req_valid); else passed++;
      checks++; if (mem_raddr !== 32'h8000_0010) $display("FAIL stall_raddr[%0d] got %h want 80000010", i, mem_raddr); else passed++;
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL accepted_req_valid got %0b want 0", mem_req_valid); else passed++;
`ifdef YSYX_23060201_IFU_PERF_EN
    checks++; if (stall_cnt !== 64'd5) $display("FAIL stall_cnt_req got %0d want 5", stall_cnt); else passed++;
`endif
    repeat (2) begin
      tick();
      checks++; if (inst_valid !== 1'b0) $display("FAIL rsp_wait_valid got %0b want 0", inst_valid); else passed++;
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1) $display("FAIL second_inst_valid got %0b want 1", inst_valid); else passed++;
    checks++; if (inst !== 32'h0010_0093) $display("FAIL second_inst got %h want 00100093", inst); else passed++;
`ifdef YSYX_23060201_IFU_PERF_EN
    checks++; if (stall_cnt !== 64'd7) $display("FAIL stall_cnt_wait got %0d want 7", stall_cnt); else passed++;
`endif
  endtask

  task automatic test_exec_align();
    inst_ready = 1'b1; dnpc_valid = 1'b0;
    tick();
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL exec_inst_valid got %0b want 0", inst_valid); else passed++;
`ifdef YSYX_23060201_IFU_PERF_EN
    checks++; if (fetch_cnt !== 64'd2) $display("FAIL fetch_cnt_two got %0d want 2", fetch_cnt); else passed++;
`endif
    repeat (2) begin
      tick();
      checks++; if (mem_req_valid !== 1'b0) $display("FAIL exec_idle_req got %0b want 0", mem_req_valid); else passed++;
      checks++; if (pc !== 32'h8000_0010) $display("FAIL exec_pc got %h want 80000010", pc); else passed++;
    end
    dnpc_valid = 1'b1; dnpc = 32'h8000_0007;
    tick();
    dnpc_valid = 1'b0;
    checks++; if (pc !== 32'h8000_0004) $display("FAIL align_pc got %h want 80000004", pc); else passed++;
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL align_req got %0b want 1", mem_req_valid); else passed++;
  endtask

  task automatic test_spurious_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hbad0_0bad; dnpc_valid = 1'b1; dnpc = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0; dnpc_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL spur_req got %0b want 1", mem_req_valid); else passed++;
    checks++; if (pc !== 32'h8000_0004) $display("FAIL spur_pc got %h want 80000004", pc); else passed++;
    checks++; if (inst !== 32'h0010_0093) $display("FAIL spur_inst got %h want 00100093", inst); else passed++;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL async_inst_valid got %0b want 0", inst_valid); else passed++;
    checks++; if (pc !== 32'h8000_0000) $display("FAIL async_pc got %h want 80000000", pc); else passed++;
    checks++; if (inst !== 32'h0) $display("FAIL async_inst got %h want 0", inst); else passed++;
`ifdef YSYX_23060201_IFU_PERF_EN
    checks++; if (fetch_cnt !== 64'd0) $display("FAIL async_fetch_cnt got %0d want 0", fetch_cnt); else passed++;
    checks++; if (stall_cnt !== 64'd0) $display("FAIL async_stall_cnt got %0d want 0", stall_cnt); else passed++;
`endif
    tick();
    rst = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL rerelease_req got %0b want 0", mem_req_valid); else passed++;
    tick();
    checks++; if (mem_raddr !== 32'h8000_0000) $display("FAIL rerelease_raddr got %h want 80000000", mem_raddr); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      checks++; if (mem_raddr !== exp_pc) $display("FAIL loop_raddr[%0d] got %h want %h", i, mem_raddr, exp_pc); else passed++;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1000 + i;
      tick();
      mem_rsp_valid = 1'b0;
      checks++; if (inst !== 32'h0000_1000 + i) $display("FAIL loop_inst[%0d] got %h want %h", i, inst, 32'h0000_1000 + i); else passed++;
      exp_pc = exp_pc + 32'd4;
      inst_ready = 1'b1; dnpc_valid = 1'b1; dnpc = exp_pc;
      tick();
      inst_ready = 1'b0; dnpc_valid = 1'b0;
    end
    checks++; if (mem_raddr !== 32'h8000_0028) $display("FAIL loop_final_raddr got %h want 80000028", mem_raddr); else passed++;
`ifdef YSYX_23060201_IFU_PERF_EN
    checks++; if (fetch_cnt !== 64'd10) $display("FAIL loop_fetch_cnt got %0d want 10", fetch_cnt); else passed++;
    checks++; if (stall_cnt !== 64'd0) $display("FAIL loop_stall_cnt got %0d want 0", stall_cnt); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_hold_backpressure();
    test_req_stall();
    test_exec_align();
    test_spurious_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_ifu.md
# ysyx_23060201_ifu

Instruction fetch unit placed upstream of the decoder (IDU) in the ysyx_23060201 core. It holds the architectural PC and issues one read request per instruction to instruction memory over a valid/ready request channel plus a valid-only response channel. It presents the fetched word to the IDU under a valid/ready handshake, then waits for the next PC (dnpc) from the EXU before fetching again. This turns the single-cycle PC/MEM path into a multicycle, latency-tolerant fetch stage.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low. Asserted (0) clears all state immediately, independent of clk.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_raddr  output  32  fetch address; equals pc.
- mem_rsp_valid  input  1  response data valid, single-cycle pulse.
- mem_rsp_data  input  32  fetched instruction word.
- inst_valid  output  1  instruction available to the IDU.
- inst_ready  input  1  IDU accepts the instruction.
- inst  output  32  registered instruction word.
- pc  output  32  address of inst and of the current fetch.
- dnpc_valid  input  1  EXU next-PC valid.
- dnpc  input  32  next PC from the EXU.
- fetch_cnt  output  64  retired-fetch counter (present only with the macro).
- stall_cnt  output  64  memory-stall cycle counter (present only with the macro).

## Operation
- States: IDLE, REQ, WAIT, HOLD, EXEC.
- Reset values: state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, mem_req_valid=0, counters=0.
- IDLE: lasts exactly one cycle after reset release, then moves to REQ. No request is issued in the cycle in which rst deasserts.
- REQ: mem_req_valid=1 and mem_raddr=pc, held stable until accepted. When mem_req_ready=1, move to WAIT.
- WAIT: when mem_rsp_valid=1, capture inst<=mem_rsp_data, set inst_valid<=1, and move to HOLD.
- HOLD: inst_valid=1, and inst and pc are held stable. When inst_ready=1, clear inst_valid. If dnpc_valid=1 in the same cycle, load pc<=dnpc and move to REQ. Otherwise move to EXEC.
- EXEC: when dnpc_valid=1, load pc<=dnpc and move to REQ.
- dnpc bits [1:0] are ignored; pc[1:0] is always 0.
- dnpc_valid is ignored in IDLE, REQ and WAIT, and also in HOLD without the handshake.
- mem_rsp_valid is ignored outside WAIT. The memory guarantees response latency ≥1 cycle after acceptance, and responses never arrive in the acceptance cycle.
- Reset mid-operation: any state returns to IDLE immediately. The memory shares rst and drops outstanding requests, so no stale response reaches the next WAIT.
- Exactly one request is outstanding at any time.

## Timing
- Request accepted in cycle t. Earliest mem_rsp_valid is t+1, and inst_valid rises in t+2.
- With an immediate IDU ready and dnpc_valid in the handshake cycle, the minimum loop is 3 cycles per instruction (REQ, WAIT, HOLD).
- inst_valid must not drop before inst_ready. inst and pc must not change while inst_valid=1.
- mem_req_valid must not drop before mem_req_ready. mem_raddr must not change while mem_req_valid=1.
- All outputs are registered or decoded from the state register only. There are no combinational input→output paths.

## Configuration
- YSYX_23060201_IFU_PERF_EN defined:
  - fetch_cnt increments on each inst_valid&&inst_ready.
  - stall_cnt increments on each cycle in REQ with mem_req_ready=0, and on each cycle in WAIT with mem_rsp_valid=0.
  - Both counters wrap modulo 2^64 and are cleared by rst.
- Not defined: fetch_cnt, stall_cnt and their logic are absent. Fetch behaviour is identical.

## Test plan
- Reset, then release rst. Expected: mem_req_valid=0 in the release cycle and =1 in the next cycle with mem_raddr=32'h8000_0000. With mem_req_ready=1, mem_rsp_valid at t+1 carrying 32'h0000_0413 gives inst_valid=1 and inst=32'h0000_0413 at t+2.
- Hold mem_req_ready=0 for 5 cycles. Expected: mem_req_valid and mem_raddr stay stable; with the macro, stall_cnt=5 after acceptance.
- Hold inst_ready=0 for 4 cycles, then pulse inst_ready and dnpc_valid together with dnpc=32'h8000_0010. Expected: inst stable throughout, then the next request goes to 32'h8000_0010 in the following cycle.
- Give dnpc=32'h8000_0007 in EXEC. Expected: pc=32'h8000_0004.
- Pulse mem_rsp_valid and dnpc_valid in REQ, then assert rst=0 in WAIT. Expected: spurious inputs have no effect, and reset forces inst_valid=0 and pc=RESET_PC asynchronously.
- Run 10 fetch/dnpc loops with the macro defined. Expected: fetch_cnt=10.
